// File: rtl/pipe_add_sub.sv
// pipe_add_sub: carry-pipelined N-bit adder/subtractor split into STAGES
// slices of W bits, with valid/ready flow control and a global stall.
module pipe_add_sub #(
   parameter int N      = 32,
   parameter int STAGES = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         sub,
   input  logic         cin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] result,
   output logic         cout,
   output logic         overflow,
   output logic         zero
);
   localparam int W = N / STAGES;

   logic         advance;
   logic [N-1:0] b_eff;
   logic         c_first;

   // The whole pipe moves together; it stalls only when a result is waiting
   // and the consumer refuses it.
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   // Subtract is A + ~B + 1, so the carry into slice 0 is forced high and cin is ignored.
   assign b_eff   = sub ? ~B : B;
   assign c_first = sub | cin;

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      logic [W-1:0]       a_sl;
      logic [W-1:0]       b_sl;
      logic               c_in;
      logic               v_in;
      logic [W:0]         s;
      logic               v_q;
      logic               c_q;
      logic [(k+1)*W-1:0] r_nxt;
      logic [(k+1)*W-1:0] r_q;

      if (k == 0) begin : g_src
         assign a_sl  = A[W-1:0];
         assign b_sl  = b_eff[W-1:0];
         assign c_in  = c_first;
         assign v_in  = in_valid;
         assign r_nxt = s[W-1:0];
      end else begin : g_src
         assign a_sl  = g_stg[k-1].g_sk.a_sk[W-1:0];
         assign b_sl  = g_stg[k-1].g_sk.b_sk[W-1:0];
         assign c_in  = g_stg[k-1].c_q;
         assign v_in  = g_stg[k-1].v_q;
         // New slice goes on top of the slices already completed (deskew).
         assign r_nxt = {s[W-1:0], g_stg[k-1].r_q};
      end

      // W-bit ripple add of this stage's slice.
      assign s = {1'b0, a_sl} + {1'b0, b_sl} + {{W{1'b0}}, c_in};

      if (k < STAGES-1) begin : g_sk
         logic [N-(k+1)*W-1:0] a_sk;
         logic [N-(k+1)*W-1:0] b_sk;

         if (k == 0) begin : g_ld
            // Skew: carry the not-yet-added upper operand slices to the next stage.
            // NOTE: clocked state uses non-blocking assignments so every stage samples the
            // pre-edge value of its neighbour; and pure datapath registers carry no reset,
            // since their contents only matter when the matching valid bit is set.
            always_ff @(posedge clk) begin
               if (advance) begin
                  a_sk <= A[N-1:W];
                  b_sk <= b_eff[N-1:W];
               end
            end
         end else begin : g_ld
            // Skew: drop the slice consumed here and pass the rest forward.
            always_ff @(posedge clk) begin
               if (advance) begin
                  a_sk <= g_stg[k-1].g_sk.a_sk[N-k*W-1:W];
                  b_sk <= g_stg[k-1].g_sk.b_sk[N-k*W-1:W];
               end
            end
         end
      end

      if (k == STAGES-1) begin : g_out
         logic ovf_q;
         logic zero_q;

         // Output stage: result and flags registered, cleared by reset, held during a stall.
         always_ff @(posedge clk) begin
            if (rst) begin
               v_q    <= 1'b0;
               c_q    <= 1'b0;
               r_q    <= '0;
               ovf_q  <= 1'b0;
               zero_q <= 1'b0;
            end else if (advance) begin
               v_q    <= v_in;
               c_q    <= s[W];
               r_q    <= r_nxt;
               // Carry into the MSB is recovered from the MSB sum bit.
               ovf_q  <= (a_sl[W-1] ^ b_sl[W-1] ^ s[W-1]) ^ s[W];
               zero_q <= (r_nxt == '0);
            end
         end
      end else begin : g_mid
         // Intermediate valid bit: cleared by reset so in-flight work is discarded.
         always_ff @(posedge clk) begin
            if (rst) begin
               v_q <= 1'b0;
            end else if (advance) begin
               v_q <= v_in;
            end
         end

         // Intermediate carry and completed result slices.
         always_ff @(posedge clk) begin
            if (advance) begin
               c_q <= s[W];
               r_q <= r_nxt;
            end
         end
      end
   end

   assign out_valid = g_stg[STAGES-1].v_q;
   assign result    = g_stg[STAGES-1].r_q;
   assign cout      = g_stg[STAGES-1].c_q;
   assign overflow  = g_stg[STAGES-1].g_out.ovf_q;
   assign zero      = g_stg[STAGES-1].g_out.zero_q;

endmodule

// File: tb/tb_pipe_add_sub.sv
// tb_pipe_add_sub: directed and random stimulus for pipe_add_sub with an
// arithmetic reference model, an in-order scoreboard and literal expectations.
module tb_pipe_add_sub;
   localparam int N      = 32;
   localparam int STAGES = 4;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic         sub;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] result;
   logic         cout;
   logic         overflow;
   logic         zero;

   pipe_add_sub #(.N(N), .STAGES(STAGES)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .sub       (sub),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cout      (cout),
      .overflow  (overflow),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] r;
      logic         c;
      logic         v;
      logic         z;
      logic         lit;
      logic [N-1:0] lr;
      logic         lc;
      logic         lv;
      logic         lz;
      int           acc;
   } exp_t;

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic         s;
      logic         c;
      logic [N-1:0] r;
      logic         co;
      logic         ov;
      logic         z;
   } vec_t;

   exp_t         q[$];
   int           checks  = 0;
   int           errors  = 0;
   int           cyc     = 0;
   bit           lat_chk = 1'b1;
   logic         lit_en;
   logic [N-1:0] lit_r;
   logic         lit_c;
   logic         lit_v;
   logic         lit_z;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain unsigned/signed arithmetic on the operands.
   function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                  input logic s, input logic c);
      exp_t   e;
      longint ua, ub, sa, sb, full_u, full_s;
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (s) begin
         full_u = ua - ub;
         full_s = sa - sb;
         e.c    = (ua >= ub);
      end else begin
         full_u = ua + ub + longint'(c);
         full_s = sa + sb + longint'(c);
         e.c    = (full_u >= 64'sh1_0000_0000);
      end
      e.r   = full_u[N-1:0];
      e.v   = (full_s > 64'sd2147483647) || (full_s < -64'sd2147483648);
      e.z   = (e.r == '0);
      e.lit = 1'b0;
      e.lr  = '0;
      e.lc  = 1'b0;
      e.lv  = 1'b0;
      e.lz  = 1'b0;
      e.acc = 0;
      return e;
   endfunction

   // Monitor: samples mid-cycle, scores every valid output, records accepted inputs.
   initial begin : mon
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            q.delete();
         end else begin
            if (out_valid) begin
               if (q.size() == 0) begin
                  check("unexpected_out_valid", 64'(out_valid), 64'(0));
               end else begin
                  e = q[0];
                  check("result",   64'(result),   64'(e.r));
                  check("cout",     64'(cout),     64'(e.c));
                  check("overflow", 64'(overflow), 64'(e.v));
                  check("zero",     64'(zero),     64'(e.z));
                  if (e.lit) begin
                     check("lit_result",   64'(result),   64'(e.lr));
                     check("lit_cout",     64'(cout),     64'(e.lc));
                     check("lit_overflow", 64'(overflow), 64'(e.lv));
                     check("lit_zero",     64'(zero),     64'(e.lz));
                  end
                  if (out_ready) begin
                     if (lat_chk) check("latency", 64'(cyc - e.acc), 64'(STAGES));
                     void'(q.pop_front());
                  end
               end
            end
            if (in_valid && in_ready) begin
               e     = model(A, B, sub, cin);
               e.lit = lit_en;
               e.lr  = lit_r;
               e.lc  = lit_c;
               e.lv  = lit_v;
               e.lz  = lit_z;
               e.acc = cyc;
               q.push_back(e);
            end
         end
      end
   end

   task automatic drive(input logic v, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic s, input logic c, input logic ordy);
      @(posedge clk);
      #1;
      in_valid  = v;
      A         = a;
      B         = b;
      sub       = s;
      cin       = c;
      out_ready = ordy;
      lit_en    = 1'b0;
   endtask

   task automatic drive_vec(input vec_t t);
      @(posedge clk);
      #1;
      in_valid  = 1'b1;
      A         = t.a;
      B         = t.b;
      sub       = t.s;
      cin       = t.c;
      out_ready = 1'b1;
      lit_en    = 1'b1;
      lit_r     = t.r;
      lit_c     = t.co;
      lit_v     = t.ov;
      lit_z     = t.z;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         drive(1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
   endtask

   task automatic rand_op(input logic ordy);
      drive(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ordy);
   endtask

   vec_t vecs[8];

   initial begin : stim
      vecs[0] = '{a: 32'hFFFFFFFF, b: 32'h00000001, s: 1'b0, c: 1'b0, r: 32'h00000000, co: 1'b1, ov: 1'b0, z: 1'b1};
      vecs[1] = '{a: 32'h80000000, b: 32'h00000001, s: 1'b1, c: 1'b0, r: 32'h7FFFFFFF, co: 1'b1, ov: 1'b1, z: 1'b0};
      vecs[2] = '{a: 32'h00000005, b: 32'h00000007, s: 1'b1, c: 1'b0, r: 32'hFFFFFFFE, co: 1'b0, ov: 1'b0, z: 1'b0};
      vecs[3] = '{a: 32'h00FFFFFF, b: 32'h00000000, s: 1'b0, c: 1'b1, r: 32'h01000000, co: 1'b0, ov: 1'b0, z: 1'b0};
      vecs[4] = '{a: 32'h00000003, b: 32'h00000001, s: 1'b1, c: 1'b1, r: 32'h00000002, co: 1'b1, ov: 1'b0, z: 1'b0};
      vecs[5] = '{a: 32'h7FFFFFFF, b: 32'h00000001, s: 1'b0, c: 1'b0, r: 32'h80000000, co: 1'b0, ov: 1'b1, z: 1'b0};
      vecs[6] = '{a: 32'h00000000, b: 32'h00000000, s: 1'b1, c: 1'b0, r: 32'h00000000, co: 1'b1, ov: 1'b0, z: 1'b1};
      vecs[7] = '{a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, s: 1'b0, c: 1'b1, r: 32'hFFFFFFFF, co: 1'b1, ov: 1'b0, z: 1'b0};

      rst       = 1'b1;
      in_valid  = 1'b0;
      A         = '0;
      B         = '0;
      sub       = 1'b0;
      cin       = 1'b0;
      out_ready = 1'b1;
      lit_en    = 1'b0;
      lit_r     = '0;
      lit_c     = 1'b0;
      lit_v     = 1'b0;
      lit_z     = 1'b0;

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_in_ready",  64'(in_ready),  64'(1));
      check("rst_result",    64'(result),    64'(0));
      check("rst_cout",      64'(cout),      64'(0));
      check("rst_overflow",  64'(overflow),  64'(0));
      check("rst_zero",      64'(zero),      64'(0));
      @(posedge clk);
      #1 rst = 1'b0;

      // Directed vectors, back to back.
      for (int i = 0; i < 8; i++) drive_vec(vecs[i]);
      idle(6);

      // Random stream of 8 with out_ready held high.
      for (int i = 0; i < 8; i++) rand_op(1'b1);
      idle(6);

      // Backpressure with a full pipeline.
      lat_chk = 1'b0;
      for (int i = 0; i < STAGES; i++) rand_op(1'b1);
      for (int i = 0; i < 3; i++) begin
         rand_op(1'b0);
         @(negedge clk);
         check("stall_in_ready",  64'(in_ready),  64'(0));
         check("stall_out_valid", 64'(out_valid), 64'(1));
      end
      idle(10);
      @(negedge clk);
      check("drain_empty", 64'(q.size()), 64'(0));
      lat_chk = 1'b1;

      // Reset with three operations in flight.
      for (int i = 0; i < 3; i++) rand_op(1'b1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      check("mid_rst_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("post_rst_out_valid", 64'(out_valid), 64'(0));
      check("post_rst_result",    64'(result),    64'(0));
      check("post_rst_cout",      64'(cout),      64'(0));
      idle(8);

      // Pipeline still works after the mid-stream reset.
      drive_vec(vecs[4]);
      drive_vec(vecs[0]);
      idle(8);
      @(negedge clk);
      check("final_empty", 64'(q.size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
